// File: rtl/mux_4_1_rr_arb.sv
// Round-robin arbiter that owns the select of a shared 4:1 mux and registers the selected word.
// Optional tenure limit: define ARB_HOLD_LIMIT_EN to cap ownership at MAX_HOLD cycles under contention.
//
// state | meaning
// IDLE  | no owner, gnt_out=0, waiting for any request
// BUSY  | one requester owns the mux until it drops its request (or its tenure expires)
module mux_4_1_rr_arb #(
  parameter int DW       = 8,
  parameter int MAX_HOLD = 15,
  parameter int CW       = 4
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic [3:0]      req_in,
  input  logic [4*DW-1:0] d_in,
  output logic [3:0]      gnt_out,
  output logic [1:0]      sel_out,
  output logic            valid_out,
  output logic [DW-1:0]   y_out
);

  typedef enum logic {IDLE, BUSY} state_t;

  if (MAX_HOLD < 1 || MAX_HOLD >= (1 << CW)) begin : g_bad_cw
    $error("CW too narrow for MAX_HOLD");
  end

  state_t          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [3:0]      gnt_q, gnt_d;
  logic [1:0]      sel_q, sel_d;
  logic            valid_q, valid_d;
  logic [DW-1:0]   y_q, y_d;
`ifdef ARB_HOLD_LIMIT_EN
  logic [CW-1:0]   cnt_q, cnt_d;
`endif

  logic            idle_found, rel_found, release_now;
  logic [1:0]      idle_idx, rel_idx, rel_ptr;
  logic [DW-1:0]   y_sel;

  // First set bit of req scanning from ptr upward, wrapping 3 -> 0.
  function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] ptr);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int i = 0; i < 4; i++) begin
      idx = ptr + i[1:0];
      if (!res[2] && req[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  always_comb begin
    y_sel = d_in[DW-1:0];
    case (sel_q)
      2'd0: y_sel = d_in[0*DW +: DW];
      2'd1: y_sel = d_in[1*DW +: DW];
      2'd2: y_sel = d_in[2*DW +: DW];
      2'd3: y_sel = d_in[3*DW +: DW];
      default: y_sel = d_in[DW-1:0];
    endcase
  end

  assign {idle_found, idle_idx} = pick(req_in, ptr_q);
  assign rel_ptr                = sel_q + 2'd1;
  assign {rel_found, rel_idx}   = pick(req_in, rel_ptr);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    valid_d     = valid_q;
    y_d         = valid_q ? y_sel : '0;
    release_now = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (idle_found) begin
          gnt_d   = 4'b0001 << idle_idx;
          sel_d   = idle_idx;
          valid_d = 1'b1;
          state_d = BUSY;
`ifdef ARB_HOLD_LIMIT_EN
          cnt_d   = CW'(1);
`endif
        end
      end
      BUSY: begin
        release_now = !req_in[sel_q];
`ifdef ARB_HOLD_LIMIT_EN
        // Expired tenure only yields when someone else is actually waiting.
        if (cnt_q == CW'(MAX_HOLD) && |(req_in & ~gnt_q)) release_now = 1'b1;
        if (cnt_q != CW'(MAX_HOLD)) cnt_d = cnt_q + CW'(1);
`endif
        if (release_now) begin
          ptr_d = rel_ptr;
          if (rel_found) begin
            gnt_d   = 4'b0001 << rel_idx;
            sel_d   = rel_idx;
`ifdef ARB_HOLD_LIMIT_EN
            cnt_d   = CW'(1);
`endif
          end else begin
            gnt_d   = 4'b0000;
            valid_d = 1'b0;
            state_d = IDLE;
`ifdef ARB_HOLD_LIMIT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      y_q     <= '0;
`ifdef ARB_HOLD_LIMIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      y_q     <= y_d;
`ifdef ARB_HOLD_LIMIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign gnt_out   = gnt_q;
  assign sel_out   = sel_q;
  assign valid_out = valid_q;
  assign y_out     = y_q;

endmodule

// File: doc/mux_4_1_rr_arb.md
Name: mux_4_1_rr_arb

Overview:
Round-robin arbiter and sequencer that shares a 4:1 data multiplexer among four requesters. It decides which requester owns the mux and drives the select. The owner keeps the mux for as long as it holds its request. The block also registers the selected data word, so it forms the controlled front end of the 4:1 datapath.

Parameters:
DW, 8, data width of each requester slice and of y_out
MAX_HOLD, 15, maximum tenure in cycles (only used with ARB_HOLD_LIMIT_EN)
CW, 4, tenure counter width; must hold MAX_HOLD

Ports:
clk_in  input  1  clock, all logic on rising edge
rst_n_in  input  1  synchronous reset, active-low
req_in  input  4  request per requester; held high for the whole tenure
d_in  input  4*DW  requester data; slice i = d_in[i*DW +: DW]
gnt_out  output  4  one-hot grant, registered
sel_out  output  2  mux select = index of granted requester, registered
valid_out  output  1  high when any grant is active
y_out  output  DW  registered mux output

Behaviour:
- Clock and reset:
  - Single clock domain.
  - Reset is synchronous and active-low: any rising edge with rst_n_in=0 applies reset.
- Reset values: gnt_out=0, sel_out=0, valid_out=0, y_out=0, priority pointer ptr=0, tenure count=0, state IDLE.
- Reset applied mid-tenure aborts the tenure at that edge. No partial release sequence runs.
- Winner function: first set bit of the candidate vector, scanning ptr, ptr+1, ... modulo 4 (3 wraps to 0).
- State IDLE:
  - If req_in!=0 at edge N, then from N+1: winner granted, gnt_out one-hot, sel_out=index, valid_out=1, state BUSY.
  - Request-to-grant latency is 1 cycle.
- State BUSY, owner k:
  - While req_in[k]=1, the grant is held. Changes on other req_in bits are ignored.
  - If req_in[k]=0 at edge N, then ptr becomes (k+1) mod 4 at N+1.
  - In the same edge, the block re-arbitrates over req_in from the new ptr.
  - If another requester is pending, its grant appears at N+1 with no idle bubble.
  - If none is pending, gnt_out=0, valid_out=0, sel_out keeps its last value, and the state returns to IDLE.
- A one-cycle drop of the owner's request forfeits the grant. The requester must then re-compete.
- y_out:
  - At each edge, y_out takes slice[sel_out] of d_in if valid_out=1, otherwise 0.
  - Owner data is therefore visible on y_out one cycle after it is presented, starting the cycle after gnt_out rises.
- Invariant: gnt_out has at most one bit set, and gnt_out==(1<<sel_out) whenever valid_out=1.
- Starvation bound without the optional feature: none, because tenure is owner-controlled. Fairness holds only between tenures.

Optional Feature:
Macro ARB_HOLD_LIMIT_EN.
- Defined:
  - The tenure counter loads 1 in the first grant cycle and increments each BUSY cycle, saturating at MAX_HOLD.
  - When the count equals MAX_HOLD and any other req_in bit is set, the next edge forces release.
  - On forced release, ptr becomes k+1 and the grant moves to the winner from ptr, with no bubble.
  - The owner therefore holds gnt_out for exactly MAX_HOLD cycles, then must re-compete.
  - If no other request is pending, the tenure continues and the counter stays saturated.
  - Voluntary release resets the counter.
- Undefined:
  - The counter and limit logic are absent.
  - Tenure is unlimited, and MAX_HOLD and CW are unused.

Test Plan:
1. Reset: rst_n_in=0 for 2 cycles with req_in=4'hF -> gnt_out=0, sel_out=0, valid_out=0, y_out=0 throughout; first grant (to 0) 1 cycle after release of reset.
2. Single request: req_in=4'b0100, slice2=8'hA5 -> next cycle gnt_out=4'b0100, sel_out=2, valid_out=1; following cycle y_out=8'hA5; drop req -> next cycle gnt_out=0, valid_out=0, y_out=0 one cycle later.
3. Rotation: req_in=4'hF, each owner drops its request after 3 granted cycles and re-raises it 1 cycle later -> grant order 0,1,2,3,0 with no gap cycles between tenures.
4. Wrap and skip: owner 3 releases with req_in=4'b0010 pending -> next cycle gnt_out=4'b0010; ptr=0 before search, request 0 idle so 1 wins.
5. Mid-tenure reset: owner 2 granted, rst_n_in=0 for 1 cycle with req_in=4'b0101 -> all outputs 0 at that edge; after reset requester 0 wins (ptr=0).
6. ARB_HOLD_LIMIT_EN, MAX_HOLD=4, req_in=4'b0011 held high -> grant alternates 0 for 4 cycles, then 1 for 4 cycles, repeating. Without the macro -> requester 0 holds indefinitely.
